// File: rtl/sprite_addr_gen.sv
// Purpose: maps a heading angle to a rotation frame and emits sprite-sheet ROM addresses, one beat or a whole frame in raster order.
// Latency: out_valid rises on the second edge after a single command is presented with cmd_ready high; a burst starts one edge later.
// Backpressure: out_valid && !out_ready freezes both stages and the burst walker; cmd_ready drops while stalled or bursting.
//
// Ports:
//   clk, rst_n (async, active-low), abort (synchronous flush)
//   cmd_valid/cmd_ready/cmd_mode/cmd_degree/cmd_x/cmd_y : command stream (mode 0 single, 1 burst)
//   out_valid/out_ready/out_addr/out_x/out_y/out_frame/out_last/out_oob : address stream
//   busy : burst in progress or any beat in flight
module sprite_addr_gen #(
    parameter int FRAME_W    = 75,
    parameter int FRAME_H    = 75,
    parameter int SHEET_COLS = 8,
    parameter int NUM_FRAMES = 16,
    parameter int COORD_W    = 7,
    parameter int ADDR_W     = 17,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          abort,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_mode,
    input  logic [8:0]                    cmd_degree,
    input  logic [COORD_W-1:0]            cmd_x,
    input  logic [COORD_W-1:0]            cmd_y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic [$clog2(NUM_FRAMES)-1:0] out_frame,
    output logic                          out_last,
    output logic                          out_oob,
    output logic                          busy
);

    localparam int FRM_W    = $clog2(NUM_FRAMES);
    localparam int COL_BITS = $clog2(SHEET_COLS);

    localparam logic [31:0] FW32        = 32'(FRAME_W);
    localparam logic [31:0] FH32        = 32'(FRAME_H);
    localparam logic [31:0] BASE32      = 32'(BASE_ADDR);
    localparam logic [31:0] COL_MASK    = 32'(SHEET_COLS - 1);
    localparam logic [31:0] ROW_STRIDE  = 32'(SHEET_COLS * FRAME_W);
    localparam logic [31:0] BAND_STRIDE = 32'(FRAME_H * SHEET_COLS * FRAME_W);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_nxt;
    logic                 stall;

    // Command decode
    logic [8:0]           deg_wrap;
    logic [FRM_W-1:0]     cmd_frame;
    logic                 cmd_oob;

    // Burst walker
    logic [FRM_W-1:0]     burst_frame;
    logic [COORD_W-1:0]   bx, by;
    logic                 burst_end;

    // Beat offered to stage A this cycle
    logic                 issue_vld;
    logic [FRM_W-1:0]     issue_frame;
    logic [COORD_W-1:0]   issue_x, issue_y;
    logic                 issue_last, issue_oob;
    logic                 start_burst;

    // Stage A
    logic                 a_vld;
    logic [FRM_W-1:0]     a_frame;
    logic [COORD_W-1:0]   a_x, a_y;
    logic                 a_last, a_oob;
    logic [31:0]          a_frame32;
    logic [ADDR_W-1:0]    a_addr;

    assign stall     = out_valid && !out_ready;
    assign cmd_ready = (state == IDLE) && !stall;
    assign busy      = (state == BURST) || a_vld || out_valid;

    // Headings 360..511 fold back once; the largest folded value (151) stays in range.
    assign deg_wrap  = (cmd_degree >= 9'd360) ? (cmd_degree - 9'd360) : cmd_degree;
    assign cmd_frame = FRM_W'((32'(deg_wrap) * 32'(NUM_FRAMES)) / 32'd360);
    assign cmd_oob   = (32'(cmd_x) >= FW32) || (32'(cmd_y) >= FH32);

    assign burst_end = (bx == X_LAST) && (by == Y_LAST);

    // Sheet row/column of the frame are a shift and a mask because SHEET_COLS is a power of two.
    // The sum is formed at 32 bits and deliberately truncated to the ROM width.
    assign a_frame32 = 32'(a_frame);
    assign a_addr    = ADDR_W'(BASE32
                               + (a_frame32 >> COL_BITS) * BAND_STRIDE
                               + 32'(a_y) * ROW_STRIDE
                               + (a_frame32 & COL_MASK) * FW32
                               + 32'(a_x));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue_vld   = 1'b0;
        issue_frame = cmd_frame;
        issue_x     = cmd_x;
        issue_y     = cmd_y;
        issue_last  = 1'b0;
        issue_oob   = 1'b0;
        start_burst = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_mode) begin
                        start_burst = 1'b1;
                        state_nxt   = BURST;
                    end else begin
                        issue_vld  = 1'b1;
                        issue_last = 1'b1;
                        issue_oob  = cmd_oob;
                    end
                end
            end
            BURST: begin
                if (!stall) begin
                    issue_vld   = 1'b1;
                    issue_frame = burst_frame;
                    issue_x     = bx;
                    issue_y     = by;
                    issue_last  = burst_end;
                    if (burst_end) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
        // abort wins over everything, including a command offered in the same cycle
        if (abort) begin
            state_nxt   = IDLE;
            issue_vld   = 1'b0;
            start_burst = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_frame <= '0;
            bx          <= '0;
            by          <= '0;
            a_vld       <= 1'b0;
            a_frame     <= '0;
            a_x         <= '0;
            a_y         <= '0;
            a_last      <= 1'b0;
            a_oob       <= 1'b0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_frame   <= '0;
            out_last    <= 1'b0;
            out_oob     <= 1'b0;
        end else if (abort) begin
            a_vld     <= 1'b0;
            a_frame   <= '0;
            a_x       <= '0;
            a_y       <= '0;
            a_last    <= 1'b0;
            a_oob     <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_frame <= '0;
            out_last  <= 1'b0;
            out_oob   <= 1'b0;
        end else begin
            if (start_burst) begin
                burst_frame <= cmd_frame;
                bx          <= '0;
                by          <= '0;
            end else if (issue_vld && (state == BURST)) begin
                if (bx == X_LAST) begin
                    bx <= '0;
                    by <= by + COORD_W'(1);
                end else begin
                    bx <= bx + COORD_W'(1);
                end
            end

            if (!stall) begin
                a_vld <= issue_vld;
                if (issue_vld) begin
                    a_frame <= issue_frame;
                    a_x     <= issue_x;
                    a_y     <= issue_y;
                    a_last  <= issue_last;
                    a_oob   <= issue_oob;
                end
                out_valid <= a_vld;
                if (a_vld) begin
                    out_addr  <= a_oob ? ADDR_W'(BASE32) : a_addr;
                    out_x     <= a_x;
                    out_y     <= a_y;
                    out_frame <= a_frame;
                    out_last  <= a_last;
                    out_oob   <= a_oob;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Purpose: directed checks of sprite_addr_gen with hand-computed addresses for the default 75x75, 8x2 sheet.
// Latency: single beats expected two edges after presentation; bursts walked beat by beat.
// Backpressure: out_ready is held low for a few cycles mid-burst to exercise the stall path.
module tb_sprite_addr_gen;

    localparam int COORD_W = 7;
    localparam int ADDR_W  = 17;
    localparam int FRM_W   = 4;

    logic               clk;
    logic               rst_n;
    logic               abort;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_mode;
    logic [8:0]         cmd_degree;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_addr;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [FRM_W-1:0]   out_frame;
    logic               out_last;
    logic               out_oob;
    logic               busy;

    int n_checks;
    int n_fail;

    sprite_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_degree (cmd_degree),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_frame  (out_frame),
        .out_last   (out_last),
        .out_oob    (out_oob),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One single-mode lookup, presented right after an edge, with out_ready high.
    task automatic single(input string tag, input int deg, input int x, input int y,
                          input int exp_frame, input int exp_addr, input int exp_oob);
        @(posedge clk); #1;
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_mode   = 1'b0;
        cmd_degree = 9'(deg);
        cmd_x      = COORD_W'(x);
        cmd_y      = COORD_W'(y);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq({tag, "_valid_early"}, 32'(out_valid), 0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 32'(out_valid), 1);
        check_eq({tag, "_frame"}, 32'(out_frame), 32'(exp_frame));
        check_eq({tag, "_addr"},  32'(out_addr),  32'(exp_addr));
        check_eq({tag, "_x"},     32'(out_x),     32'(x));
        check_eq({tag, "_y"},     32'(out_y),     32'(y));
        check_eq({tag, "_last"},  32'(out_last),  1);
        check_eq({tag, "_oob"},   32'(out_oob),   32'(exp_oob));
    endtask

    // Burst at heading 90 (frame 4: sheet row 0, column 4 -> column offset 300, row stride 600).
    // stall_at >= 0 holds out_ready low for 3 cycles when that beat is presented.
    // kill_at >= 0 interrupts the burst at that beat, by abort or by reset.
    task automatic burst(input string tag, input int stall_at, input int kill_at, input bit kill_rst);
        int  cnt;
        int  seq_err;
        int  n_last;
        int  rdy_err;
        int  stall_n;
        int  ex;
        int  ey;
        int  exp_addr;
        bit  done;
        cnt = 0; seq_err = 0; n_last = 0; rdy_err = 0; stall_n = 0; ex = 0; ey = 0; done = 1'b0;

        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_mode   = 1'b1;
        cmd_degree = 9'd90;
        cmd_x      = COORD_W'(5);
        cmd_y      = COORD_W'(9);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;

        for (int cyc = 0; cyc < 7000 && !done; cyc++) begin
            if (cnt < 5600 && cmd_ready) rdy_err++;
            if (kill_at >= 0 && cnt == kill_at && out_valid) begin
                if (kill_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq({tag, "_rst_valid"}, 32'(out_valid), 0);
                    check_eq({tag, "_rst_ready"}, 32'(cmd_ready), 1);
                    check_eq({tag, "_rst_busy"},  32'(busy), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (3) @(posedge clk);
                    #1;
                    check_eq({tag, "_rst_no_beat"}, 32'(out_valid), 0);
                end else begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    check_eq({tag, "_abort_valid"}, 32'(out_valid), 0);
                    check_eq({tag, "_abort_ready"}, 32'(cmd_ready), 1);
                    check_eq({tag, "_abort_busy"},  32'(busy), 0);
                    @(posedge clk); #1;
                    check_eq({tag, "_abort_drained"}, 32'(out_valid), 0);
                end
                done = 1'b1;
            end else if (out_valid && cnt == stall_at && stall_n < 3) begin
                out_ready = 1'b0;
                stall_n++;
                // beat 100 is x=25, y=1 -> 300 + 600 + 25
                check_eq({tag, "_stall_addr"}, 32'(out_addr), 925);
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    exp_addr = 300 + ey * 600 + ex;
                    if (32'(out_addr) != 32'(exp_addr) || 32'(out_x) != 32'(ex) || 32'(out_y) != 32'(ey)
                        || out_frame != 4'd4 || out_oob || (out_last != (cnt == 5624)))
                        seq_err++;
                    if (out_last) n_last++;
                    if (cnt == 0)  check_eq({tag, "_beat0"},  32'(out_addr), 300);
                    if (cnt == 74) check_eq({tag, "_beat74"}, 32'(out_addr), 374);
                    if (cnt == 75) check_eq({tag, "_beat75"}, 32'(out_addr), 900);
                    if (out_last) begin
                        check_eq({tag, "_last_addr"}, 32'(out_addr), 44774);
                        done = 1'b1;
                    end
                    cnt++;
                    if (ex == 74) begin
                        ex = 0;
                        ey++;
                    end else begin
                        ex++;
                    end
                end
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end

        out_ready = 1'b1;
        if (kill_at >= 0) begin
            check_eq({tag, "_kill_point"}, 32'(cnt), 32'(kill_at));
        end else begin
            check_eq({tag, "_beats"},   32'(cnt), 5625);
            check_eq({tag, "_n_last"},  32'(n_last), 1);
            check_eq({tag, "_stalls"},  32'(stall_n), (stall_at >= 0) ? 32'd3 : 32'd0);
        end
        check_eq({tag, "_seq_errs"},  32'(seq_err), 0);
        check_eq({tag, "_ready_hi"},  32'(rdy_err), 0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        abort      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 1'b0;
        cmd_degree = '0;
        cmd_x      = '0;
        cmd_y      = '0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        check_eq("rst_busy",      32'(busy), 0);
        check_eq("rst_out_addr",  32'(out_addr), 0);
        check_eq("rst_out_last",  32'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        single("s_deg0",     0,  0,  0,  0,     0, 0);
        single("s_deg359", 359, 74, 74, 15, 89999, 0);
        single("s_deg23",   23, 10,  2,  1,  1285, 0);
        single("s_deg22",   22,  0,  0,  0,     0, 0);
        single("s_deg400", 400,  0,  0,  1,    75, 0);
        single("s_oob_x",  400, 75,  0,  1,     0, 1);
        single("s_deg180", 180,  3,  4,  8, 47403, 0);
        single("s_deg511", 511,  1,  1,  6,  1051, 0);

        // abort in the same cycle as a command: the command must not enter the pipeline
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_mode   = 1'b0;
        cmd_degree = 9'd0;
        cmd_x      = '0;
        cmd_y      = '0;
        abort      = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check_eq("abort_pri_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check_eq("abort_pri_valid", 32'(out_valid), 0);

        burst("b_full",  -1, -1, 1'b0);
        burst("b_stall", 100, -1, 1'b0);
        burst("b_abort", -1, 50, 1'b0);
        single("s_post_abort", 23, 10, 2, 1, 1285, 0);
        burst("b_reset", -1, 50, 1'b1);
        single("s_post_reset", 359, 74, 74, 15, 89999, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
